// File: rtl/hmi_switch_debounce_irq.sv
// hmi_switch_debounce_irq: Avalon-MM controller for the HMI slide-switch bank.
// Synchronises the raw pins, optionally debounces them, and captures per-bit
// edges into a W1C register. A maskable, registered level interrupt is raised.
// Optional feature macro: HMI_SWITCH_DEBOUNCE_EN. When it is defined, per-bit
// debounce counters are built in. Otherwise the debounced state is simply the
// synchroniser output.
`timescale 1ns/1ps
module hmi_switch_debounce_irq #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd2;
  localparam logic [1:0] ADDR_EDGEMODE = 2'd3;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [1:0]       edge_mode;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect &  write_n;

  // Only the low bits of writedata are meaningful for any register.
  assign unused_wdata = ^writedata;

  // First synchroniser stage, shared by both build variants.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_meta <= '0;
    else          sync_meta <= in_port;
  end

`ifdef HMI_SWITCH_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_out;

  // Second synchroniser stage feeding the debouncers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_out <= '0;
    else          sync_out <= sync_meta;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          mismatch;

    assign mismatch = sync_out[i] ^ state[i];

    // Count consecutive mismatching cycles; any match restarts the count.
    // NOTE: each counter is an individual flop with async reset, so a partial
    // count is discarded whenever reset is asserted.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        cnt <= '0;
      else if (!mismatch || cnt == CNT_LAST) cnt <= '0;
      else                                 cnt <= cnt + CW'(1);
    end

    // Accept the new level on the last mismatching cycle.
    assign state_next[i] = (mismatch && cnt == CNT_LAST) ? ~state[i] : state[i];
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  // The state register itself acts as the second synchroniser stage.
  assign state_next = sync_meta;
`endif

  // Edge events are seen on the same edge the state register changes; the
  // mode register value before any same-edge write decides what is captured.
  assign edge_set = ( state_next & ~state & {WIDTH{edge_mode[0]}})
                  | (~state_next &  state & {WIDTH{edge_mode[1]}});
  assign edge_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Debounced state, control registers, edge capture and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= '0;
      irq_mask  <= '0;
      edge_cap  <= '0;
      edge_mode <= '0;
      irq       <= 1'b0;
    end else begin
      state    <= state_next;
      // Set wins over a simultaneous W1C of the same bit.
      edge_cap <= (edge_cap & ~edge_clr) | edge_set;
      irq      <= |(edge_cap & irq_mask);
      if (wr_en && address == ADDR_IRQMASK)  irq_mask  <= writedata[WIDTH-1:0];
      if (wr_en && address == ADDR_EDGEMODE) edge_mode <= writedata[1:0];
    end
  end

  // Read data selection; unused upper bits read as zero.
  // NOTE: default assignment first so no path leaves rd_mux unassigned (no latch).
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux[WIDTH-1:0] = state;
      ADDR_IRQMASK:  rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP:  rd_mux[WIDTH-1:0] = edge_cap;
      ADDR_EDGEMODE: rd_mux[1:0]       = edge_mode;
      default:       rd_mux            = '0;
    endcase
  end

  // Registered read port: updates on every read cycle, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_hmi_switch_debounce_irq.sv
// tb_hmi_switch_debounce_irq: self-checking bench for hmi_switch_debounce_irq.
// Reads push their expected value into a scoreboard queue; a monitor pops and
// compares when readdata is produced. Build with or without
// HMI_SWITCH_DEBOUNCE_EN; expected latencies follow the selected variant.
`timescale 1ns/1ps
module tb_hmi_switch_debounce_irq;

  localparam int WIDTH = 10;
  localparam int DEB   = 4;
`ifdef HMI_SWITCH_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [WIDTH-1:0]  in_port;
  logic              irq;

  exp_t sb[$];
  logic issued;
  int   n_checks;
  int   n_fail;

  hmi_switch_debounce_irq #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Marks cycles where the DUT was asked for read data.
  always @(posedge clk) issued <= chipselect && write_n;

  // Scoreboard monitor: compare each produced read against its expectation.
  always @(negedge clk) begin
    if (issued) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.tag, readdata, e.data);
      end
    end
  end

  task automatic cyc_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic cyc_read(input logic [1:0] a, input logic [31:0] e, input string tag);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    sb.push_back('{tag: tag, data: e});
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic cyc_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic settle();
    repeat (LAT + 2) cyc_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    issued     = 1'b0;
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    in_port    = '1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;

    // Reset with all pins high: nothing may leak through.
    repeat (3) begin
      @(negedge clk);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_readdata", readdata, 32'd0);
    end
    reset_n = 1'b1;
    in_port = '0;
    cyc_read(2'd0, 32'd0, "rst_data");
    cyc_read(2'd1, 32'd0, "rst_irqmask");
    cyc_read(2'd2, 32'd0, "rst_edgecap");
    cyc_read(2'd3, 32'd0, "rst_edgemode");
    check("rst_irq_after", {31'd0, irq}, 32'd0);

    // Pin-to-DATA latency on bit 0.
    in_port[0] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++)
      cyc_read(2'd0, (k >= LAT + 1) ? 32'h1 : 32'h0, "data_latency");
    in_port[0] = 1'b0;
    settle();
    cyc_read(2'd0, 32'h0, "data_fall");

`ifdef HMI_SWITCH_DEBOUNCE_EN
    // A 3-cycle pulse is shorter than the debounce window.
    in_port[0] = 1'b1;
    repeat (3) cyc_idle();
    in_port[0] = 1'b0;
    for (int k = 1; k <= LAT + 2; k++)
      cyc_read(2'd0, 32'h0, "deb_short_pulse");
`else
    // Without debounce a 1-cycle pulse passes through 2 cycles late.
    cyc_write(2'd3, 32'd3);
    in_port[3] = 1'b1;
    cyc_read(2'd0, 32'h0, "pulse_e1");
    in_port[3] = 1'b0;
    cyc_read(2'd0, 32'h0, "pulse_e2");
    cyc_read(2'd0, 32'h8, "pulse_e3");
    cyc_read(2'd0, 32'h0, "pulse_e4");
    cyc_read(2'd2, 32'h8, "pulse_edgecap");
    cyc_write(2'd2, 32'h3FF);
    cyc_write(2'd3, 32'd0);
    cyc_read(2'd2, 32'h0, "pulse_cleared");
`endif

    // DATA is read-only.
    cyc_write(2'd0, 32'hFFFF_FFFF);
    cyc_read(2'd0, 32'h0, "data_ro");

    // Rising capture with interrupt on bit 2.
    cyc_write(2'd3, 32'd1);
    cyc_write(2'd1, 32'h004);
    cyc_read(2'd3, 32'd1, "edgemode_rb");
    cyc_read(2'd1, 32'h004, "irqmask_rb");
    in_port[2] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      cyc_read(2'd2, (k >= LAT + 1) ? 32'h004 : 32'h0, "cap_rise");
      check("irq_rise", {31'd0, irq}, (k >= LAT + 1) ? 32'd1 : 32'd0);
    end
    cyc_write(2'd2, 32'h004);
    check("irq_hold_after_w1c", {31'd0, irq}, 32'd1);
    cyc_idle();
    check("irq_drop_after_w1c", {31'd0, irq}, 32'd0);
    cyc_read(2'd2, 32'h0, "cap_w1c");

    // Falling edge is ignored in rising mode; falling mode filters rises.
    in_port[2] = 1'b0;
    settle();
    cyc_read(2'd2, 32'h0, "fall_in_rise_mode");
    cyc_write(2'd3, 32'd2);
    in_port[5] = 1'b1;
    settle();
    cyc_read(2'd2, 32'h0, "mf_after_rise");
    in_port[5] = 1'b0;
    settle();
    cyc_read(2'd2, 32'h020, "mf_after_fall");
    check("mf_irq_masked", {31'd0, irq}, 32'd0);
    cyc_write(2'd3, 32'd0);
    cyc_read(2'd2, 32'h020, "mode_no_retro");
    cyc_write(2'd2, 32'h020);
    in_port[5] = 1'b1;
    settle();
    in_port[5] = 1'b0;
    settle();
    cyc_read(2'd2, 32'h0, "mode_none");

    // W1C on the same edge as a new bit-1 edge: set wins.
    cyc_write(2'd3, 32'd3);
    cyc_write(2'd1, 32'h002);
    in_port[1] = 1'b1;
    repeat (LAT - 1) cyc_idle();
    cyc_write(2'd2, 32'h002);
    cyc_read(2'd2, 32'h002, "set_over_clr");
    check("irq_bit1", {31'd0, irq}, 32'd1);
    cyc_write(2'd2, 32'h0);
    cyc_read(2'd2, 32'h002, "w1c_zero_keeps");

    // Clearing IRQMASK drops irq one cycle later.
    cyc_write(2'd1, 32'h0);
    check("irq_hold_after_mask", {31'd0, irq}, 32'd1);
    cyc_idle();
    check("irq_drop_after_mask", {31'd0, irq}, 32'd0);
    cyc_write(2'd2, 32'h002);
    cyc_read(2'd2, 32'h0, "cap_final_clear");
    cyc_read(2'd0, 32'h002, "data_final");

    repeat (3) cyc_idle();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
